boomerang_sequencer: RTL and testbench
======================================

Name: boomerang_sequencer

Overview:
Controls the two chained LED counters (forward sweep, then reverse sweep). It debounces the go button and issues start pulses to the forward and reverse counters in turn. It repeats the forward/reverse pair NUM_BOUNCES times, watches each leg with a timeout watchdog and drives the green status LED. It sits in top between the raw buttons and the counter instances, replacing the direct done-to-go chaining.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable clk cycles required before the debounced go level changes (2..65535)
NUM_BOUNCES, 3, forward+reverse pairs per go press (1..255)
TIMEOUT_CYCLES, 1000000, max clk cycles to wait for a done before the error state (2..2^24-1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_btn  input  1  asynchronous active-low reset, clears all state
go_btn  input  1  raw go button, active-low, asynchronous to clk
done_fwd  input  1  done from forward counter, level, synchronous to clk
done_rev  input  1  done from reverse counter, level, synchronous to clk
go_fwd  output  1  one-cycle start pulse to forward counter
go_rev  output  1  one-cycle start pulse to reverse counter
busy  output  1  high while a sequence is in progress
green  output  1  high after successful completion, until next accepted go
error  output  1  high after a watchdog timeout, until next accepted go
bounce_cnt  output  8  completed forward+reverse pairs in current/last run

Behaviour:
- Reset (rst_btn low, async): all outputs 0, FSM in IDLE, sync/debounce state is go-released, edge-detect registers 0.
- Go path: go_btn inverted → 2-flop synchronizer → debounce counter. The counter increments while the synchronized value differs from the debounced level and clears when they match. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
- go_req is a one-cycle pulse on the debounced rising edge only; release generates nothing.
- done_fwd/done_rev are rising-edge detected with a registered previous value. A done held high does not retrigger.
- FSM states: IDLE, START_FWD, WAIT_FWD, START_REV, WAIT_REV, FINISH, ERROR.
  - IDLE: on go_req → START_FWD; clear green, error and bounce_cnt in the same edge.
  - ERROR: on go_req, same transition and clears as IDLE.
  - START_FWD: go_fwd=1 for exactly this one cycle → WAIT_FWD. Watchdog cleared.
  - WAIT_FWD: done_fwd rise → START_REV. Otherwise, if the watchdog reaches TIMEOUT_CYCLES-1 → ERROR.
  - START_REV: go_rev=1 for one cycle → WAIT_REV. Watchdog cleared.
  - WAIT_REV: on done_rev rise, bounce_cnt increments. If the new value equals NUM_BOUNCES → FINISH; else → START_FWD. Timeout → ERROR as above.
  - FINISH: green set to 1 → IDLE next cycle.
  - ERROR: error=1 and held until the next go_req.
- busy = 1 in START_FWD, WAIT_FWD, START_REV, WAIT_REV and FINISH; 0 in IDLE and ERROR.
- go_req while busy is ignored and dropped, not queued.
- A done edge from the counter not currently awaited is ignored; e.g. done_rev in WAIT_FWD.
- A done rise on the same cycle the watchdog expires: done wins.
- Watchdog: 24-bit counter, increments only in WAIT_* states.
- bounce_cnt: 8-bit; never exceeds NUM_BOUNCES.
- Reset mid-sequence: immediate return to reset values, no pulse completes. A go_btn held low through reset release produces exactly one go_req after debounce.
- All outputs are registered (no combinational path input→output).

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, NUM_BOUNCES=2, TIMEOUT_CYCLES=16; counter models assert done 5 cycles after their go pulse.
1. Press go_btn low and hold it; release it; press and release again while busy → exactly one go_fwd. Sequence go_fwd, go_rev, go_fwd, go_rev, each pulse exactly 1 cycle wide. bounce_cnt goes 0→1→2, then green=1, busy=0, error=0.
2. Glitch go_btn low for 3 cycles, then high → no go_req, no go_fwd; FSM stays IDLE.
3. Forward model never asserts done → error=1 exactly 16 cycles after go_fwd, busy=0, no go_rev. A new press clears error and restarts with go_fwd.
4. done_rev pulse injected during WAIT_FWD, and done_fwd held high across two legs → ignored. Exactly NUM_BOUNCES pairs complete, green=1.
5. Assert rst_btn low during WAIT_REV → all outputs 0 asynchronously, before the next clk edge. After release with go_btn idle → remains IDLE.
6. done_fwd rises on the timeout cycle (15th wait cycle) → transition to START_REV, error stays 0.

Source files
------------

// File: rtl/boomerang_sequencer_if.sv
// Bundle of the button, counter handshake and status signals around the
// boomerang sequencer. The master modport is the sequencer side and the
// slave modport is the button/counter/LED side.
interface boomerang_sequencer_if;
  logic       go_btn;
  logic       done_fwd;
  logic       done_rev;
  logic       go_fwd;
  logic       go_rev;
  logic       busy;
  logic       green;
  logic       error;
  logic [7:0] bounce_cnt;

  modport master (
    input  go_btn,
    input  done_fwd,
    input  done_rev,
    output go_fwd,
    output go_rev,
    output busy,
    output green,
    output error,
    output bounce_cnt
  );

  modport slave (
    output go_btn,
    output done_fwd,
    output done_rev,
    input  go_fwd,
    input  go_rev,
    input  busy,
    input  green,
    input  error,
    input  bounce_cnt
  );
endinterface

// File: rtl/boomerang_sequencer.sv
// Boomerang sequencer: debounces the go button, then runs NUM_BOUNCES
// forward/reverse counter legs. Each leg is guarded by a watchdog. The LED
// and status outputs are all registered.
module boomerang_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned NUM_BOUNCES     = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                   clk,
  input  logic                   rst_btn,
  boomerang_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START_FWD = 3'd1,
    S_WAIT_FWD  = 3'd2,
    S_START_REV = 3'd3,
    S_WAIT_REV  = 3'd4,
    S_FINISH    = 3'd5,
    S_ERROR     = 3'd6
  } state_e;

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  // The watchdog checks the value it is about to count up to. A leg therefore
  // times out on its TIMEOUT_CYCLES-1'th wait cycle. A done edge arriving on
  // that same cycle still takes priority.
  localparam logic [23:0] WD_LAST  = 24'(TIMEOUT_CYCLES - 2);
  localparam logic [7:0]  NB       = 8'(NUM_BOUNCES);

  // Input conditioning state.
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        deb_level_q, deb_level_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic        go_req_q, go_req_d;
  logic        done_fwd_prev_q, done_fwd_prev_d;
  logic        done_rev_prev_q, done_rev_prev_d;
  logic        done_fwd_rise_s;
  logic        done_rev_rise_s;

  // Sequencer state and registered outputs.
  state_e      state_q, state_d;
  logic [23:0] wdog_q, wdog_d;
  logic [7:0]  bounce_q, bounce_d;
  logic [7:0]  bounce_inc_s;
  logic        go_fwd_q, go_fwd_d;
  logic        go_rev_q, go_rev_d;
  logic        busy_q, busy_d;
  logic        green_q, green_d;
  logic        error_q, error_d;

  // Synchronise and debounce the active-low button, and detect rising edges on go and done.
  always_comb begin
    sync1_d         = ~bus.go_btn;
    sync2_d         = sync1_q;
    deb_level_d     = deb_level_q;
    deb_cnt_d       = deb_cnt_q;
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_level_d = sync2_q;
        deb_cnt_d   = 16'd0;
      end else begin
        deb_cnt_d   = deb_cnt_q + 16'd1;
      end
    end else begin
      deb_cnt_d     = 16'd0;
    end
    go_req_d        = deb_level_d & ~deb_level_q;
    done_fwd_prev_d = bus.done_fwd;
    done_rev_prev_d = bus.done_rev;
    done_fwd_rise_s = bus.done_fwd & ~done_fwd_prev_q;
    done_rev_rise_s = bus.done_rev & ~done_rev_prev_q;
  end

  // Input conditioning registers. At reset they read as "button released".
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1_q         <= 1'b0;
      sync2_q         <= 1'b0;
      deb_level_q     <= 1'b0;
      deb_cnt_q       <= 16'd0;
      go_req_q        <= 1'b0;
      done_fwd_prev_q <= 1'b0;
      done_rev_prev_q <= 1'b0;
    end else begin
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      deb_level_q     <= deb_level_d;
      deb_cnt_q       <= deb_cnt_d;
      go_req_q        <= go_req_d;
      done_fwd_prev_q <= done_fwd_prev_d;
      done_rev_prev_q <= done_rev_prev_d;
    end
  end

  // Sequencer next-state logic. The outputs are decoded from the next state so that their flops line up with the state flops.
  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    bounce_d     = bounce_q;
    green_d      = green_q;
    error_d      = error_q;
    bounce_inc_s = bounce_q + 8'd1;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (go_req_q) begin
          state_d  = S_START_FWD;
          green_d  = 1'b0;
          error_d  = 1'b0;
          bounce_d = 8'd0;
        end else begin
          state_d  = state_q;
        end
      end
      S_START_FWD: begin
        state_d = S_WAIT_FWD;
        wdog_d  = 24'd0;
      end
      S_WAIT_FWD: begin
        if (done_fwd_rise_s) begin
          state_d = S_START_REV;
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          wdog_d  = wdog_q + 24'd1;
        end
      end
      S_START_REV: begin
        state_d = S_WAIT_REV;
        wdog_d  = 24'd0;
      end
      S_WAIT_REV: begin
        if (done_rev_rise_s) begin
          bounce_d = bounce_inc_s;
          if (bounce_inc_s == NB) begin
            state_d = S_FINISH;
            green_d = 1'b1;
          end else begin
            state_d = S_START_FWD;
          end
        end else if (wdog_q == WD_LAST) begin
          state_d = S_ERROR;
          error_d = 1'b1;
        end else begin
          wdog_d  = wdog_q + 24'd1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    go_fwd_d = (state_d == S_START_FWD);
    go_rev_d = (state_d == S_START_REV);
    busy_d   = (state_d == S_START_FWD) || (state_d == S_WAIT_FWD) ||
               (state_d == S_START_REV) || (state_d == S_WAIT_REV) ||
               (state_d == S_FINISH);
  end

  // Sequencer state, watchdog and registered outputs.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q  <= S_IDLE;
      wdog_q   <= 24'd0;
      bounce_q <= 8'd0;
      go_fwd_q <= 1'b0;
      go_rev_q <= 1'b0;
      busy_q   <= 1'b0;
      green_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wdog_q   <= wdog_d;
      bounce_q <= bounce_d;
      go_fwd_q <= go_fwd_d;
      go_rev_q <= go_rev_d;
      busy_q   <= busy_d;
      green_q  <= green_d;
      error_q  <= error_d;
    end
  end

  assign bus.go_fwd     = go_fwd_q;
  assign bus.go_rev     = go_rev_q;
  assign bus.busy       = busy_q;
  assign bus.green      = green_q;
  assign bus.error      = error_q;
  assign bus.bounce_cnt = bounce_q;

endmodule

// File: tb/tb_boomerang_sequencer.sv
// Directed bench for boomerang_sequencer. It uses simple forward/reverse
// counter models that raise done a programmable number of cycles after their
// go pulse.
module tb_boomerang_sequencer;

  logic clk;
  logic rst_btn;
  logic go_btn;
  logic fwd_done;
  logic rev_done;
  logic fwd_en;
  int   fwd_delay;
  logic inj_active;
  logic inj_val;

  int n_cmp;
  int n_bad;

  int   fwd_pulses;
  int   rev_pulses;
  int   width_err;
  logic fwd_prev;
  logic rev_prev;
  logic [7:0] last_fwd_bc;

  boomerang_sequencer_if bus ();

  assign bus.go_btn   = go_btn;
  assign bus.done_fwd = fwd_done;
  assign bus.done_rev = inj_active ? inj_val : rev_done;

  boomerang_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .NUM_BOUNCES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk    (clk),
    .rst_btn(rst_btn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward counter model: drops done on go_fwd and raises it fwd_delay cycles later.
  always begin
    @(negedge clk);
    if (bus.go_fwd === 1'b1) begin
      fwd_done = 1'b0;
      if (fwd_en) begin
        repeat (fwd_delay) @(negedge clk);
        fwd_done = 1'b1;
      end
    end
  end

  // Reverse counter model: drops done on go_rev and raises it 5 cycles later.
  always begin
    @(negedge clk);
    if (bus.go_rev === 1'b1) begin
      rev_done = 1'b0;
      repeat (5) @(negedge clk);
      rev_done = 1'b1;
    end
  end

  // Pulse monitor: counts go pulses, flags any pulse wider than one cycle, and logs bounce_cnt at each go_fwd.
  always @(negedge clk) begin
    if (bus.go_fwd === 1'b1) begin
      if (fwd_prev) width_err <= width_err + 1;
      else begin
        fwd_pulses  <= fwd_pulses + 1;
        last_fwd_bc <= bus.bounce_cnt;
      end
    end
    if (bus.go_rev === 1'b1) begin
      if (rev_prev) width_err <= width_err + 1;
      else rev_pulses <= rev_pulses + 1;
    end
    fwd_prev <= bus.go_fwd;
    rev_prev <= bus.go_rev;
  end

  task automatic release_btn();
    go_btn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.go_fwd, bus.go_rev, bus.busy, bus.green, bus.error, bus.bounce_cnt} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {bus.go_fwd, bus.go_rev, bus.busy, bus.green, bus.error, bus.bounce_cnt});
    end
    rst_btn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_full_sequence();
    int f0, r0, w0, n;
    f0 = fwd_pulses; r0 = rev_pulses; w0 = width_err;
    go_btn = 1'b0;
    n = 0;
    while (bus.go_fwd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 40) begin n_bad++; $display("FAIL seq_go_fwd_seen: got none expected go_fwd"); end
    n_cmp++;
    if (bus.bounce_cnt !== 8'd0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL seq_first_leg: got bc=%0d busy=%b expected bc=0 busy=1", bus.bounce_cnt, bus.busy);
    end
    repeat (2) @(negedge clk);
    go_btn = 1'b1;
    repeat (8) @(negedge clk);
    go_btn = 1'b0;
    repeat (8) @(negedge clk);
    go_btn = 1'b1;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 100) begin n_bad++; $display("FAIL seq_done_wait: got busy stuck expected idle"); end
    repeat (12) @(negedge clk);
    n_cmp++;
    if (fwd_pulses - f0 !== 2 || rev_pulses - r0 !== 2) begin
      n_bad++; $display("FAIL seq_pulse_count: got fwd=%0d rev=%0d expected fwd=2 rev=2", fwd_pulses - f0, rev_pulses - r0);
    end
    n_cmp++;
    if (width_err - w0 !== 0) begin
      n_bad++; $display("FAIL seq_pulse_width: got %0d wide pulses expected 0", width_err - w0);
    end
    n_cmp++;
    if (last_fwd_bc !== 8'd1) begin
      n_bad++; $display("FAIL seq_bc_second_leg: got %0d expected 1", last_fwd_bc);
    end
    n_cmp++;
    if (bus.bounce_cnt !== 8'd2 || bus.green !== 1'b1 || bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL seq_final: got bc=%0d green=%b error=%b busy=%b expected 2 1 0 0",
                        bus.bounce_cnt, bus.green, bus.error, bus.busy);
    end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = fwd_pulses;
    go_btn = 1'b0;
    repeat (3) @(negedge clk);
    go_btn = 1'b1;
    repeat (15) @(negedge clk);
    n_cmp++;
    if (fwd_pulses - f0 !== 0) begin
      n_bad++; $display("FAIL glitch_no_go: got %0d go_fwd expected 0", fwd_pulses - f0);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.green !== 1'b1) begin
      n_bad++; $display("FAIL glitch_idle: got busy=%b green=%b expected busy=0 green=1", bus.busy, bus.green);
    end
  endtask

  task automatic test_timeout();
    int r0, n, m;
    r0 = rev_pulses;
    fwd_en = 1'b0;
    go_btn = 1'b0;
    n = 0;
    while (bus.go_fwd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    go_btn = 1'b1;
    m = 0;
    while (bus.error !== 1'b1 && m < 40) begin @(negedge clk); m++; end
    n_cmp++;
    if (m !== 16) begin
      n_bad++; $display("FAIL timeout_latency: got %0d cycles expected 16", m);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.green !== 1'b0 || rev_pulses - r0 !== 0) begin
      n_bad++; $display("FAIL timeout_state: got busy=%b green=%b go_rev=%0d expected 0 0 0",
                        bus.busy, bus.green, rev_pulses - r0);
    end
    repeat (10) @(negedge clk);
    fwd_en = 1'b1;
    go_btn = 1'b0;
    n = 0;
    while (bus.go_fwd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n >= 40 || bus.error !== 1'b0) begin
      n_bad++; $display("FAIL timeout_restart: got wait=%0d error=%b expected go_fwd with error=0", n, bus.error);
    end
    go_btn = 1'b1;
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (bus.green !== 1'b1 || bus.bounce_cnt !== 8'd2) begin
      n_bad++; $display("FAIL timeout_rerun: got green=%b bc=%0d expected 1 2", bus.green, bus.bounce_cnt);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_ignored_done();
    int f0, r0, n;
    f0 = fwd_pulses; r0 = rev_pulses;
    go_btn = 1'b0;
    n = 0;
    while (bus.go_fwd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    go_btn = 1'b1;
    @(negedge clk); inj_active = 1'b1; inj_val = 1'b0;
    @(negedge clk); inj_val = 1'b1;
    @(negedge clk); inj_val = 1'b0;
    @(negedge clk); inj_active = 1'b0;
    n = 4;
    while (bus.go_rev !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n !== 6) begin
      n_bad++; $display("FAIL ignore_first_rev: got go_rev after %0d cycles expected 6", n);
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (fwd_pulses - f0 !== 2 || rev_pulses - r0 !== 2 || bus.bounce_cnt !== 8'd2 || bus.green !== 1'b1) begin
      n_bad++; $display("FAIL ignore_pairs: got fwd=%0d rev=%0d bc=%0d green=%b expected 2 2 2 1",
                        fwd_pulses - f0, rev_pulses - r0, bus.bounce_cnt, bus.green);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int f0, n;
    f0 = fwd_pulses;
    go_btn = 1'b0;
    n = 0;
    while (bus.go_fwd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    go_btn = 1'b1;
    n = 0;
    while (bus.go_rev !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy);
    end
    #1 rst_btn = 1'b0;
    #1;
    n_cmp++;
    if ({bus.go_fwd, bus.go_rev, bus.busy, bus.green, bus.error, bus.bounce_cnt} !== 13'd0) begin
      n_bad++; $display("FAIL rstmid_async_clear: got %b expected all zero",
                        {bus.go_fwd, bus.go_rev, bus.busy, bus.green, bus.error, bus.bounce_cnt});
    end
    @(negedge clk);
    rst_btn = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0 || fwd_pulses - f0 !== 1) begin
      n_bad++; $display("FAIL rstmid_stays_idle: got busy=%b go_fwd=%0d expected busy=0 go_fwd=1",
                        bus.busy, fwd_pulses - f0);
    end
    f0 = fwd_pulses;
    go_btn = 1'b0;
    rst_btn = 1'b0;
    repeat (3) @(negedge clk);
    rst_btn = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (fwd_pulses - f0 !== 1) begin
      n_bad++; $display("FAIL rst_held_go: got %0d go_fwd expected 1", fwd_pulses - f0);
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    go_btn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_done_on_timeout();
    int n;
    fwd_delay = 15;
    go_btn = 1'b0;
    n = 0;
    while (bus.go_fwd !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    go_btn = 1'b1;
    n = 0;
    while (bus.go_rev !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_cmp++;
    if (n !== 16 || bus.error !== 1'b0) begin
      n_bad++; $display("FAIL edge_timeout_done: got go_rev after %0d error=%b expected 16 error=0", n, bus.error);
    end
    n = 0;
    while (bus.busy !== 1'b0 && n < 150) begin @(negedge clk); n++; end
    n_cmp++;
    if (bus.green !== 1'b1 || bus.error !== 1'b0) begin
      n_bad++; $display("FAIL edge_timeout_final: got green=%b error=%b expected 1 0", bus.green, bus.error);
    end
    fwd_delay = 5;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    fwd_pulses = 0; rev_pulses = 0; width_err = 0;
    fwd_prev = 1'b0; rev_prev = 1'b0; last_fwd_bc = 8'd0;
    rst_btn = 1'b0; go_btn = 1'b1;
    fwd_done = 1'b0; rev_done = 1'b0;
    fwd_en = 1'b1; fwd_delay = 5;
    inj_active = 1'b0; inj_val = 1'b0;
    test_reset();
    test_full_sequence();
    test_glitch();
    test_timeout();
    test_ignored_done();
    test_reset_mid();
    test_done_on_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
